// File: rtl/tron_pkg.sv
// Shared types and helpers for the Tron memory-port arbiter.
package tron_pkg;

  localparam int MAX_CH   = 8;
  localparam int MAX_CH_W = 3;

  // Channel-id width, never narrower than one bit.
  function automatic int ch_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [MAX_CH_W-1:0] ch;
  } rsp_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first valid channel at or after the pointer, pointer moves past the winner.
module rr_arbiter
  import tron_pkg::*;
#(
  parameter  int NUM_CH = 2,
  localparam int CH_W   = ch_id_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] i_valid,
  output logic [NUM_CH-1:0] o_grant,
  output logic [CH_W-1:0]   o_winner,
  output logic              o_any
);

  logic [CH_W-1:0] r_rr_ptr;
  logic [CH_W-1:0] w_ptr_nxt;

  always_comb begin
    int              idx;
    logic [CH_W-1:0] w_idx;
    idx      = 0;
    w_idx    = '0;
    o_grant  = '0;
    o_winner = '0;
    o_any    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      w_idx = CH_W'(idx);
      if (!o_any && !reset && i_valid[w_idx]) begin
        o_any    = 1'b1;
        o_winner = w_idx;
      end
    end
    if (o_any) o_grant[o_winner] = 1'b1;
  end

  always_comb begin
    w_ptr_nxt = r_rr_ptr;
    if (o_any) w_ptr_nxt = (int'(o_winner) == NUM_CH - 1) ? '0 : o_winner + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) r_rr_ptr <= '0;
    else       r_rr_ptr <= w_ptr_nxt;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel valid/ready arbiter onto memory port 2 with tagged read return.
// Optional per-channel grant counters when MEMARB_STATS_EN is defined.
module mem_port_arbiter
  import tron_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int NUM_CH = 2,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        i_req_valid,
  output logic [NUM_CH-1:0]        o_req_ready,
  input  logic [NUM_CH-1:0]        i_req_we,
  input  logic [NUM_CH*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_CH*DATA_W-1:0] i_req_wdata,
  output logic [NUM_CH-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]        o_rsp_data,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic [DATA_W-1:0]        o_mem_din,
  output logic                     o_mem_we,
  input  logic [DATA_W-1:0]        i_mem_dout
`ifdef MEMARB_STATS_EN
  ,
  output logic [NUM_CH*16-1:0]     o_stat_grants
`endif
);

  localparam int CH_W = ch_id_w(NUM_CH);

  logic [CH_W-1:0] w_winner;
  logic            w_any;
  rsp_tag_t        w_tag_in;
  rsp_tag_t        w_tag_out;
  rsp_tag_t        r_pipe [RD_LAT];

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_valid  (i_req_valid),
    .o_grant  (o_req_ready),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // Winner is 0 when idle, so the memory sees channel-0 fields with we low.
  always_comb begin
    o_mem_addr = i_req_addr[w_winner*ADDR_W +: ADDR_W];
    o_mem_din  = i_req_wdata[w_winner*DATA_W +: DATA_W];
    o_mem_we   = w_any & i_req_we[w_winner];
  end

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_any & ~i_req_we[w_winner];
    w_tag_in.ch    = MAX_CH_W'(w_winner);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_tag_in;
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_tag_out = r_pipe[RD_LAT-1];

  // Read data is only presented alongside its tag; it reads as zero otherwise.
  always_comb begin
    o_rsp_valid = '0;
    for (int i = 0; i < NUM_CH; i++)
      o_rsp_valid[i] = w_tag_out.valid && (w_tag_out.ch == MAX_CH_W'(i));
    o_rsp_data = w_tag_out.valid ? i_mem_dout : '0;
  end

`ifdef MEMARB_STATS_EN
  logic [15:0] r_stat [NUM_CH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset)
        r_stat[i] <= '0;
      else if (o_req_ready[i] && i_req_valid[i] && r_stat[i] != 16'hFFFF)
        r_stat[i] <= r_stat[i] + 16'd1;
    end
  end

  always_comb begin
    o_stat_grants = '0;
    for (int i = 0; i < NUM_CH; i++) o_stat_grants[i*16 +: 16] = r_stat[i];
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three configurations (2ch/lat1, 4ch/lat2, 3ch/lat3) against a reference model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  v [3];
  logic [3:0]  w [3];
  logic [15:0] ad [3][4];
  logic [15:0] wd [3][4];

  logic [3:0]  rdy [3];
  logic [3:0]  rv [3];
  logic [15:0] rdata [3];
  logic [15:0] maddr [3];
  logic [15:0] mdin [3];
  logic [15:0] mdout [3];
  logic        mwe [3];

  logic [1:0] rdy_a, rv_a;
  logic [3:0] rdy_b, rv_b;
  logic [2:0] rdy_c, rv_c;
`ifdef MEMARB_STATS_EN
  logic [31:0] stat_a;
  logic [63:0] stat_b;
  logic [47:0] stat_c;
`endif

  mem_port_arbiter #(.NUM_CH(2), .RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset),
    .i_req_valid(v[0][1:0]), .o_req_ready(rdy_a), .i_req_we(w[0][1:0]),
    .i_req_addr({ad[0][1], ad[0][0]}), .i_req_wdata({wd[0][1], wd[0][0]}),
    .o_rsp_valid(rv_a), .o_rsp_data(rdata[0]),
    .o_mem_addr(maddr[0]), .o_mem_din(mdin[0]), .o_mem_we(mwe[0]), .i_mem_dout(mdout[0])
`ifdef MEMARB_STATS_EN
    , .o_stat_grants(stat_a)
`endif
  );

  mem_port_arbiter #(.NUM_CH(4), .RD_LAT(2)) dut_b (
    .clk(clk), .reset(reset),
    .i_req_valid(v[1]), .o_req_ready(rdy_b), .i_req_we(w[1]),
    .i_req_addr({ad[1][3], ad[1][2], ad[1][1], ad[1][0]}),
    .i_req_wdata({wd[1][3], wd[1][2], wd[1][1], wd[1][0]}),
    .o_rsp_valid(rv_b), .o_rsp_data(rdata[1]),
    .o_mem_addr(maddr[1]), .o_mem_din(mdin[1]), .o_mem_we(mwe[1]), .i_mem_dout(mdout[1])
`ifdef MEMARB_STATS_EN
    , .o_stat_grants(stat_b)
`endif
  );

  mem_port_arbiter #(.NUM_CH(3), .RD_LAT(3)) dut_c (
    .clk(clk), .reset(reset),
    .i_req_valid(v[2][2:0]), .o_req_ready(rdy_c), .i_req_we(w[2][2:0]),
    .i_req_addr({ad[2][2], ad[2][1], ad[2][0]}),
    .i_req_wdata({wd[2][2], wd[2][1], wd[2][0]}),
    .o_rsp_valid(rv_c), .o_rsp_data(rdata[2]),
    .o_mem_addr(maddr[2]), .o_mem_din(mdin[2]), .o_mem_we(mwe[2]), .i_mem_dout(mdout[2])
`ifdef MEMARB_STATS_EN
    , .o_stat_grants(stat_c)
`endif
  );

  assign rdy[0] = {2'b00, rdy_a};
  assign rdy[1] = rdy_b;
  assign rdy[2] = {1'b0, rdy_c};
  assign rv[0]  = {2'b00, rv_a};
  assign rv[1]  = rv_b;
  assign rv[2]  = {1'b0, rv_c};

  // Memory device per DUT: read latency g+1, old data on read-during-write.
  for (genvar g = 0; g < 3; g++) begin : g_mem
    logic [15:0] st [256] = '{default: 16'h0};
    logic [15:0] pl [3];
    always @(posedge clk) begin
      if (mwe[g]) st[maddr[g][7:0]] <= mdin[g];
      pl[0] <= st[maddr[g][7:0]];
      pl[1] <= pl[0];
      pl[2] <= pl[1];
    end
    assign mdout[g] = pl[g];
  end

  typedef struct {
    int          d;
    int          due;
    int          ch;
    logic [15:0] data;
  } exp_t;

  exp_t        q[$];
  logic [15:0] img [3][256];
  int          mp [3];
  int          scnt [3][4];
  logic [3:0]  gnt [3];
  logic [3:0]  obs_rdy [3];
  logic [3:0]  obs_rv [3];
  logic [15:0] obs_rdata [3];
  int          total, bad, cyc;

  function automatic int nch(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 4 : 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic clr();
    for (int d = 0; d < 3; d++) begin
      v[d] = '0;
      w[d] = '0;
      for (int c = 0; c < 4; c++) begin
        ad[d][c] = '0;
        wd[d][c] = '0;
      end
    end
  endtask

  // One clock cycle: compare every DUT with the model, then advance model and clock.
  task automatic do_cycle();
    exp_t        nq[$];
    exp_t        e;
    int          win, n, c;
    logic [3:0]  eg, erv;
    logic [15:0] edat;
    #2;
    for (int d = 0; d < 3; d++) begin
      n   = nch(d);
      win = -1;
      eg  = '0;
      if (!reset)
        for (int k = 0; k < n; k++) begin
          c = (mp[d] + k) % n;
          if (win < 0 && v[d][c]) win = c;
        end
      if (win >= 0) eg[win] = 1'b1;
      gnt[d]       = eg;
      obs_rdy[d]   = rdy[d];
      obs_rv[d]    = rv[d];
      obs_rdata[d] = rdata[d];
      check($sformatf("ready%0d", d), 32'(rdy[d]), 32'(eg));
      check($sformatf("mem_we%0d", d), 32'(mwe[d]), (win >= 0) ? 32'(w[d][win]) : 32'd0);
      if (win >= 0) begin
        check($sformatf("mem_addr%0d", d), 32'(maddr[d]), 32'(ad[d][win]));
        if (w[d][win]) check($sformatf("mem_din%0d", d), 32'(mdin[d]), 32'(wd[d][win]));
      end
      erv  = '0;
      edat = '0;
      foreach (q[i])
        if (q[i].d == d && q[i].due == cyc) begin
          erv[q[i].ch] = 1'b1;
          edat         = q[i].data;
        end
      check($sformatf("rsp_valid%0d", d), 32'(rv[d]), 32'(erv));
      if (erv != 0) check($sformatf("rsp_data%0d", d), 32'(rdata[d]), 32'(edat));
      if (win >= 0) begin
        if (w[d][win]) begin
          img[d][ad[d][win][7:0]] = wd[d][win];
        end else begin
          e.d    = d;
          e.due  = cyc + d + 1;
          e.ch   = win;
          e.data = img[d][ad[d][win][7:0]];
          q.push_back(e);
        end
        mp[d] = (win == n - 1) ? 0 : win + 1;
        if (scnt[d][win] < 65535) scnt[d][win]++;
      end
      if (reset) begin
        mp[d] = 0;
        for (int k = 0; k < 4; k++) scnt[d][k] = 0;
      end
    end
    if (reset) q.delete();
    else begin
      foreach (q[i]) if (q[i].due > cyc) nq.push_back(q[i]);
      q = nq;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] dc [3];
    total = 0;
    bad   = 0;
    cyc   = 0;
    for (int d = 0; d < 3; d++) begin
      mp[d] = 0;
      gnt[d] = '0;
      for (int k = 0; k < 4; k++) scnt[d][k] = 0;
      for (int a = 0; a < 256; a++) img[d][a] = 16'h0;
    end
    clr();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset with every channel requesting: nothing may be granted.
    for (int d = 0; d < 3; d++) v[d] = 4'hF;
    do_cycle();
    do_cycle();
    check("rst_ready_b", 32'(obs_rdy[1]), 32'd0);
    reset = 1'b0;
    clr();
    check("rst_ptr_a", 32'(dut_a.u_arb.r_rr_ptr), 32'd0);
    check("rst_ptr_c", 32'(dut_c.u_arb.r_rr_ptr), 32'd0);
    do_cycle();
    check("rst_rsp_a", 32'(obs_rv[0]), 32'd0);

    // 2ch/lat1: write then read back.
    v[0] = 4'b0001; w[0] = 4'b0001; ad[0][0] = 16'h0040; wd[0][0] = 16'hBEEF;
    do_cycle();
    w[0] = 4'b0000;
    do_cycle();
    check("a_read_grant", 32'(obs_rdy[0]), 32'b01);
    clr();
    do_cycle();
    check("a_rsp_valid", 32'(obs_rv[0]), 32'b01);
    check("a_rsp_data", 32'(obs_rdata[0]), 32'hBEEF);

    // 4ch: all valid for 8 cycles, strict rotation.
    for (int i = 0; i < 8; i++) begin
      v[1] = 4'hF; w[1] = 4'hF;
      for (int c = 0; c < 4; c++) begin
        ad[1][c] = 16'(8 + c);
        wd[1][c] = 16'($urandom);
      end
      do_cycle();
      check($sformatf("b_rot%0d", i), 32'(obs_rdy[1]), 32'(1 << (i % 4)));
    end
    clr();

    // 3ch/lat3: preload 0x10..0x12 through ch0, then back-to-back reads.
    for (int i = 0; i < 3; i++) begin
      dc[i] = 16'($urandom);
      v[2] = 4'b0001; w[2] = 4'b0001; ad[2][0] = 16'(16 + i); wd[2][0] = dc[i];
      do_cycle();
    end
    clr();
    v[2] = 4'b0100; ad[2][2] = 16'h0010;
    do_cycle();
    check("c_rd_ch2", 32'(obs_rdy[2]), 32'b100);
    clr();
    v[2] = 4'b0001; ad[2][0] = 16'h0011;
    do_cycle();
    clr();
    v[2] = 4'b0010; ad[2][1] = 16'h0012;
    do_cycle();
    check("c_ptr_before_wrap", 32'(dut_c.u_arb.r_rr_ptr), 32'd2);
    clr();
    v[2] = 4'b0010; w[2] = 4'b0010; ad[2][1] = 16'h0020; wd[2][1] = 16'h1234;
    do_cycle();
    check("c_wrap_grant", 32'(obs_rdy[2]), 32'b010);
    check("c_ptr_after_wrap", 32'(dut_c.u_arb.r_rr_ptr), 32'd2);
    check("c_rsp0", 32'(obs_rv[2]), 32'b100);
    check("c_dat0", 32'(obs_rdata[2]), 32'(dc[0]));
    clr();
    do_cycle();
    check("c_rsp1", 32'(obs_rv[2]), 32'b001);
    check("c_dat1", 32'(obs_rdata[2]), 32'(dc[1]));
    do_cycle();
    check("c_rsp2", 32'(obs_rv[2]), 32'b010);
    check("c_dat2", 32'(obs_rdata[2]), 32'(dc[2]));

    // Random traffic; a pending request is held until granted.
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 3; d++)
        for (int c = 0; c < nch(d); c++)
          if (!v[d][c] || gnt[d][c]) begin
            v[d][c]  = 1'($urandom_range(0, 1));
            w[d][c]  = 1'($urandom_range(0, 1));
            ad[d][c] = 16'($urandom_range(0, 15));
            wd[d][c] = 16'($urandom);
          end
      do_cycle();
    end
    clr();
    for (int i = 0; i < 5; i++) do_cycle();

    // 4ch/lat2: reset one cycle after a read is accepted drops the read.
    v[1] = 4'b0010; ad[1][1] = 16'h0005;
    do_cycle();
    check("b_read_grant", 32'(obs_rdy[1]), 32'b0010);
    reset = 1'b1;
    v[1]  = 4'hF;
    do_cycle();
    check("b_rst_ready", 32'(obs_rdy[1]), 32'd0);
    do_cycle();
    check("b_rst_no_rsp", 32'(obs_rv[1]), 32'd0);
    reset = 1'b0;
    clr();
    check("b_rst_ptr", 32'(dut_b.u_arb.r_rr_ptr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      do_cycle();
      check($sformatf("b_dropped%0d", i), 32'(obs_rv[1]), 32'd0);
    end

`ifdef MEMARB_STATS_EN
    v[0] = 4'b0001; w[0] = 4'b0001; ad[0][0] = 16'h0000;
    for (int i = 0; i < 70000; i++) begin
      wd[0][0] = 16'($urandom);
      do_cycle();
    end
    clr();
    do_cycle();
    check("stat_ch0_sat", 32'(stat_a[15:0]), 32'hFFFF);
    check("stat_ch1_zero", 32'(stat_a[31:16]), 32'd0);
    check("stat_ch0_model", 32'(stat_a[15:0]), 32'(scnt[0][0]));
    for (int c = 0; c < 4; c++)
      check($sformatf("stat_b%0d", c), 32'(stat_b[c*16 +: 16]), 32'(scnt[1][c]));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
